kboard_pwm: RTL and testbench
=============================

Name: kboard_pwm

Overview:
- 3-column x 4-row matrix keypad scanner with one 8-bit level register per column; the three levels drive three PWM channels (R, G, B).
- Column 0 controls byte 0 / channel 0, column 1 controls byte 1 / channel 1, column 2 controls byte 2 / channel 2.
- Sits between the board keypad pins and the RGB LED drivers; the 24-bit level word is also exported for status logic.

Parameters:
- SCAN_DIV, 25000, clk cycles each column stays selected (1 ms at 25 MHz); minimum 2.
- DEBOUNCE_CNT, 4, consecutive identical samples of a key required to change its debounced state; range 1..8.
- STEP, 16, increment/decrement amount applied to a level byte.
- PWM_DIV, 1, clk cycles per PWM counter tick; minimum 1.
- REPEAT_VISITS, 64, column visits between auto-repeat steps (optional feature only).

Ports:
- clk  in  1  system clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- col_data  in  4  row inputs, active-low (pulled up externally; a pressed key reads 0)
- col_power  out  3  column drive, one-hot active-low (selected column = 0)
- data  out  24  level bytes: [7:0] column 0, [15:8] column 1, [23:16] column 2
- pwm_out  out  3  PWM outputs, active-high; bit i is driven by data byte i

Behaviour:
- Reset values (applied on the rst clock edge):
  - col_power = 3'b110 (column 0 selected).
  - data = 0 and pwm_out = 0.
  - All counters, debounce history and debounced key states = 0 (all keys released).
- Scan sequence:
  - Each column is held selected for exactly SCAN_DIV cycles, in the order 0 -> 1 -> 2 -> 0.
  - col_power is registered.
  - The rows are sampled once per visit, on the last cycle of the slot, so they have settled. The sample is ~col_data (1 = pressed).
- Debounce:
  - Each of the 12 keys keeps its last DEBOUNCE_CNT samples.
  - The debounced state goes to 1 when all stored samples are 1, and to 0 when all are 0; otherwise it holds.
- Actions:
  - An action fires only on a 0->1 edge of a key's debounced state.
  - Row 0: level = min(level + STEP, 255).
  - Row 1: level = max(level - STEP, 0).
  - Row 2: level = 255.
  - Row 3: level = 0.
  - Arithmetic is 9-bit with saturation; the level never wraps.
- Simultaneous edges in one column visit: only one action is applied. Priority is row3 > row2 > row0 > row1.
- Timing: data updates on the clock edge after the sampling cycle (1 cycle latency from the sample).
- Key release produces no action.
- A key held through reset produces an action only after reset has released, once it has been debounced as pressed.
- PWM:
  - An 8-bit counter pc counts 0..254 and wraps to 0, advancing once per PWM_DIV clk cycles. Period = 255 x PWM_DIV cycles.
  - Each channel latches its duty byte from data when pc wraps to 0. A change to data mid-period has no effect until the next period.
  - pwm_out[i] is registered and equals (pc < duty_latched[i]).
  - duty 0 gives a constant 0; duty 255 gives a constant 1; duty N gives exactly N high ticks per period.
- Reset mid-operation returns every element to its reset value on the next edge. pwm_out is 0 for the first full period after reset.

Optional Feature:
- Macro: KBOARD_AUTOREPEAT_EN.
- Defined:
  - While the row 0 or row 1 key stays debounced-pressed, its action repeats every REPEAT_VISITS visits of its column, counted from the initial press edge.
  - Each column has its own repeat counter, cleared on release.
  - Rows 2 and 3 never repeat.
- Undefined: one action per press edge only; no repeat counters are synthesized.

Test Plan:
- Reset, with SCAN_DIV=4, DEBOUNCE_CNT=2 -> col_power cycles 110, 101, 011, each held for 4 cycles; data=0; pwm_out=000.
- Hold column 1 row 2 (col_data[2]=0 while col_power=101) for 2 visits -> data[15:8]=0xFF on the cycle after the 2nd sample; other bytes stay 0.
- Press column 0 row 0 seventeen separate times -> data[7:0] steps 0x10, 0x20 ... 0xF0, then 0xFF and stays at 0xFF. Then one row 1 press -> 0xEF.
- A single-visit glitch on column 2 row 3 with DEBOUNCE_CNT=2 -> no change. Column 2 rows 0 and 3 pressed together after the level is set to 0x40 -> level 0x00 (row 3 wins).
- PWM_DIV=1, data byte 0 = 0x40 -> pwm_out[0] is high for 64 of every 255 cycles. Duty 0x00 -> always low; 0xFF -> always high. A duty change mid-period applies only from the next wrap.
- With KBOARD_AUTOREPEAT_EN and REPEAT_VISITS=4, row 0 held -> the level rises by STEP at the press edge, then every 4 column visits, and saturates at 0xFF. Without the macro -> a single step only.

Source files
------------

// File: rtl/kboard_pwm_if.sv
// Keypad/LED pin bundle for kboard_pwm; master is the scanner, slave is the board/status side.
interface kboard_pwm_if;
    logic [3:0]  col_data;
    logic [2:0]  col_power;
    logic [23:0] data;
    logic [2:0]  pwm_out;

    modport master (
        input  col_data,
        output col_power,
        output data,
        output pwm_out
    );

    modport slave (
        output col_data,
        input  col_power,
        input  data,
        input  pwm_out
    );
endinterface

// File: rtl/kboard_pwm.sv
// 3x4 keypad scanner with debounced per-column level bytes driving three PWM channels.
// Define KBOARD_AUTOREPEAT_EN to make held row 0/1 keys repeat every REPEAT_VISITS column visits.
module kboard_pwm #(
    parameter int unsigned SCAN_DIV      = 25000,
    parameter int unsigned DEBOUNCE_CNT  = 4,
    parameter int unsigned STEP          = 16,
    parameter int unsigned PWM_DIV       = 1,
    parameter int unsigned REPEAT_VISITS = 64
) (
    input  logic         clk,
    input  logic         rst,
    kboard_pwm_if.master kb
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned PDIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned D      = DEBOUNCE_CNT;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [PDIV_W-1:0] PDIV_LAST = PDIV_W'(PWM_DIV - 1);
    localparam logic [8:0]        STEP9     = 9'(STEP);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_e;

    col_e                  col_q, col_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [2:0]            col_power_q, col_power_d;
    logic                  slot_end;
    logic [1:0]            col_idx;

    logic [2:0][3:0][D-1:0] hist_q, hist_d;
    logic [2:0][3:0]        deb_q, deb_d;
    logic [2:0][7:0]        data_q, data_d;

    logic [3:0]            sample;
    logic [3:0]            cur_deb;
    logic [3:0][D-1:0]     new_hist;
    logic [3:0]            new_deb;
    logic [3:0]            press_edge;
    logic [3:0]            rpt_act;
    logic [3:0]            act;
    logic [7:0]            lvl;
    logic [8:0]            lvl_inc;
    logic [8:0]            lvl_dec;

    logic [PDIV_W-1:0]     pdiv_q, pdiv_d;
    logic                  ptick;
    logic [7:0]            pc_q, pc_d;
    logic [2:0][7:0]       duty_q, duty_d;
    logic [2:0]            pwm_q, pwm_d;

    // Column scan FSM: col_power is computed from the next column so it switches with col_q.
    always_comb begin
        col_d      = col_q;
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        slot_end   = (scan_cnt_q == SCAN_LAST);
        if (slot_end) begin
            scan_cnt_d = '0;
            unique case (col_q)
                COL0:    col_d = COL1;
                COL1:    col_d = COL2;
                default: col_d = COL0;
            endcase
        end
        unique case (col_d)
            COL0:    col_power_d = 3'b110;
            COL1:    col_power_d = 3'b101;
            default: col_power_d = 3'b011;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= COL0;
            scan_cnt_q  <= '0;
            col_power_q <= 3'b110;
        end else begin
            col_q       <= col_d;
            scan_cnt_q  <= scan_cnt_d;
            col_power_q <= col_power_d;
        end
    end

    // Debounce of the selected column: shift in the new sample, settle only on a uniform history.
    always_comb begin
        col_idx  = col_q;
        sample   = ~kb.col_data;
        cur_deb  = deb_q[col_idx];
        new_hist = '0;
        new_deb  = cur_deb;
        for (int unsigned r = 0; r < 4; r++) begin
            new_hist[r] = D'({hist_q[col_idx][r], sample[r]});
            if (&new_hist[r]) begin
                new_deb[r] = 1'b1;
            end else if (~|new_hist[r]) begin
                new_deb[r] = 1'b0;
            end
        end
        press_edge = new_deb & ~cur_deb;
    end

`ifdef KBOARD_AUTOREPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_VISITS > 1) ? $clog2(REPEAT_VISITS) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_VISITS - 1);

    logic [2:0][RPT_W-1:0] rpt_q, rpt_d;

    // Visits since the last row 0/1 press edge; wraps to zero on each repeat.
    always_comb begin
        rpt_d   = rpt_q;
        rpt_act = '0;
        if (slot_end) begin
            if (|press_edge[1:0]) begin
                rpt_d[col_idx] = '0;
            end else if (|new_deb[1:0]) begin
                if (rpt_q[col_idx] == RPT_LAST) begin
                    rpt_d[col_idx] = '0;
                    rpt_act        = {2'b00, new_deb[1:0]};
                end else begin
                    rpt_d[col_idx] = rpt_q[col_idx] + RPT_W'(1);
                end
            end else begin
                rpt_d[col_idx] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    always_comb begin
        rpt_act = '0;
    end
`endif

    // One action per visit, priority row3 > row2 > row0 > row1; 9-bit math saturates.
    always_comb begin
        hist_d  = hist_q;
        deb_d   = deb_q;
        data_d  = data_q;
        act     = press_edge | rpt_act;
        lvl     = data_q[col_idx];
        lvl_inc = {1'b0, lvl} + STEP9;
        lvl_dec = {1'b0, lvl} - STEP9;
        if (slot_end) begin
            hist_d[col_idx] = new_hist;
            deb_d[col_idx]  = new_deb;
            if (act[3]) begin
                data_d[col_idx] = 8'h00;
            end else if (act[2]) begin
                data_d[col_idx] = 8'hFF;
            end else if (act[0]) begin
                data_d[col_idx] = lvl_inc[8] ? 8'hFF : lvl_inc[7:0];
            end else if (act[1]) begin
                data_d[col_idx] = lvl_dec[8] ? 8'h00 : lvl_dec[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            deb_q  <= '0;
            data_q <= '0;
        end else begin
            hist_q <= hist_d;
            deb_q  <= deb_d;
            data_q <= data_d;
        end
    end

    // PWM: pc runs 0..254; duties are captured from data only on the wrap.
    always_comb begin
        ptick  = (pdiv_q == PDIV_LAST);
        pdiv_d = ptick ? '0 : pdiv_q + PDIV_W'(1);
        pc_d   = pc_q;
        duty_d = duty_q;
        if (ptick) begin
            if (pc_q == 8'd254) begin
                pc_d   = '0;
                duty_d = data_q;
            end else begin
                pc_d = pc_q + 8'd1;
            end
        end
        for (int unsigned i = 0; i < 3; i++) begin
            pwm_d[i] = (pc_q < duty_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pdiv_q <= '0;
            pc_q   <= '0;
            duty_q <= '0;
            pwm_q  <= '0;
        end else begin
            pdiv_q <= pdiv_d;
            pc_q   <= pc_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign kb.col_power = col_power_q;
    assign kb.data      = data_q;
    assign kb.pwm_out   = pwm_q;

endmodule

// File: tb/tb_kboard_pwm.sv
// Randomised and directed bench for kboard_pwm against a cycle-indexed behavioural keypad/PWM model.
module tb_kboard_pwm;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned STEP     = 16;
    localparam int unsigned PWM_DIV  = 1;
    localparam int unsigned RPT      = 4;
    localparam int          PERIOD   = 255 * PWM_DIV;
    localparam int          HOLD     = 2 * 3 * SCAN_DIV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kboard_pwm_if kb ();

    kboard_pwm #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_CNT  (DEB),
        .STEP          (STEP),
        .PWM_DIV       (PWM_DIV),
        .REPEAT_VISITS (RPT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kb  (kb)
    );

    bit keys [3][4];

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        logic [3:0] p;
        p = '0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (kb.col_power[c] == 1'b0 && keys[c][r]) p[r] = 1'b1;
            end
        end
        kb.col_data = ~p;
    end

    int n_cmp = 0;
    int n_err = 0;

    int   n;
    int   lvl   [3];
    int   run   [12];
    bit   lastv [12];
    bit   mdeb  [12];
    int   vis   [3];
    int   ev    [3];
    int   duty  [3];
    logic [2:0] m_pwm;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_pwm = '0;
        for (int i = 0; i < 3; i++) begin
            lvl[i] = 0; vis[i] = 0; ev[i] = 0; duty[i] = 0;
        end
        for (int k = 0; k < 12; k++) begin
            run[k] = DEB; lastv[k] = 1'b0; mdeb[k] = 1'b0;
        end
    endtask

    // Compare cycle n against the model, then advance the model across the next rising edge.
    task automatic tick();
        int         c;
        int         k;
        logic [2:0] ecp;
        logic [23:0] ed;
        logic [3:0] e;
        logic [2:0] pn;
        c   = (n / SCAN_DIV) % 3;
        ecp = 3'b111;
        ecp[c] = 1'b0;
        ed  = {8'(lvl[2]), 8'(lvl[1]), 8'(lvl[0])};
        check_eq("col_power", 32'(kb.col_power), 32'(ecp));
        check_eq("data", 32'(kb.data), 32'(ed));
        check_eq("pwm_out", 32'(kb.pwm_out), 32'(m_pwm));

        for (int i = 0; i < 3; i++) pn[i] = (((n / PWM_DIV) % 255) < duty[i]);
        if ((n + 1) % PERIOD == 0) begin
            for (int i = 0; i < 3; i++) duty[i] = lvl[i];
        end
        m_pwm = pn;

        if (n % SCAN_DIV == SCAN_DIV - 1) begin
            e = '0;
            for (int r = 0; r < 4; r++) begin
                k = c * 4 + r;
                if (keys[c][r] == lastv[k]) begin
                    run[k]++;
                end else begin
                    lastv[k] = keys[c][r];
                    run[k]   = 1;
                end
                if (run[k] >= DEB && lastv[k] != mdeb[k]) begin
                    e[r]    = lastv[k];
                    mdeb[k] = lastv[k];
                end
            end
            vis[c]++;
`ifdef KBOARD_AUTOREPEAT_EN
            if (e[0] || e[1]) begin
                ev[c] = vis[c];
            end else if (mdeb[c*4] || mdeb[c*4+1]) begin
                if ((vis[c] - ev[c]) % RPT == 0) begin
                    e[0] = mdeb[c*4];
                    e[1] = mdeb[c*4+1];
                end
            end
`endif
            if (e[3])      lvl[c] = 0;
            else if (e[2]) lvl[c] = 255;
            else if (e[0]) lvl[c] = (lvl[c] + STEP > 255) ? 255 : lvl[c] + STEP;
            else if (e[1]) lvl[c] = (lvl[c] < STEP) ? 0 : lvl[c] - STEP;
        end
        n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic press(input int c, input int r);
        keys[c][r] = 1'b1;
        repeat (HOLD) tick();
        keys[c][r] = 1'b0;
        repeat (HOLD) tick();
    endtask

    // Count channel-0 high cycles over one full period that uses a single latched duty.
    task automatic count_period(input int chg_at, output int cnt);
        cnt = 0;
        while (n % PERIOD != 1) tick();
        for (int j = 0; j < PERIOD; j++) begin
            if (j == chg_at) keys[0][3] = 1'b1;
            if (j == chg_at + HOLD) keys[0][3] = 1'b0;
            if (kb.pwm_out[0]) cnt++;
            tick();
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) for (int r = 0; r < 4; r++) keys[c][r] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        repeat (3 * 3 * SCAN_DIV) tick();

        keys[1][2] = 1'b1;
        repeat (HOLD) tick();
        keys[1][2] = 1'b0;
        repeat (HOLD) tick();
        check_eq("c1r2_full", 32'(kb.data), 32'h00FF00);

        for (int i = 0; i < 17; i++) press(0, 0);
        check_eq("inc_sat", 32'(kb.data[7:0]), 32'hFF);
        press(0, 1);
        check_eq("dec_from_ff", 32'(kb.data[7:0]), 32'hEF);

        keys[2][3] = 1'b1;
        repeat (3 * SCAN_DIV) tick();
        keys[2][3] = 1'b0;
        repeat (HOLD) tick();
        for (int i = 0; i < 4; i++) press(2, 0);
        check_eq("c2_level40", 32'(kb.data[23:16]), 32'h40);
        keys[2][0] = 1'b1;
        keys[2][3] = 1'b1;
        repeat (HOLD) tick();
        keys[2][0] = 1'b0;
        keys[2][3] = 1'b0;
        repeat (HOLD) tick();
        check_eq("row3_wins", 32'(kb.data[23:16]), 32'h00);

        press(0, 3);
        for (int i = 0; i < 4; i++) press(0, 0);
        count_period(-1, cnt);
        count_period(-1, cnt);
        check_eq("pwm_duty40", 32'(cnt), 32'd64);
        press(0, 3);
        count_period(-1, cnt);
        count_period(-1, cnt);
        check_eq("pwm_duty00", 32'(cnt), 32'd0);
        press(0, 2);
        count_period(-1, cnt);
        count_period(-1, cnt);
        check_eq("pwm_dutyff", 32'(cnt), 32'd255);
        count_period(100, cnt);
        check_eq("pwm_midchg", 32'(cnt), 32'd255);
        count_period(-1, cnt);
        check_eq("pwm_nextper", 32'(cnt), 32'd0);

        press(1, 3);
        keys[1][0] = 1'b1;
        repeat (14 * 3 * SCAN_DIV) tick();
`ifdef KBOARD_AUTOREPEAT_EN
        check_eq("repeat_lvl", 32'(kb.data[15:8]), 32'h40);
`else
        check_eq("repeat_lvl", 32'(kb.data[15:8]), 32'h10);
`endif
        repeat (70 * 3 * SCAN_DIV) tick();
`ifdef KBOARD_AUTOREPEAT_EN
        check_eq("repeat_sat", 32'(kb.data[15:8]), 32'hFF);
`else
        check_eq("repeat_sat", 32'(kb.data[15:8]), 32'h10);
`endif
        keys[1][0] = 1'b0;
        repeat (HOLD) tick();

        repeat (80) begin
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 4; r++) keys[c][r] = ($urandom_range(3) == 0);
            end
            if ($urandom_range(19) == 0) do_reset();
            repeat ($urandom_range(40, 4)) tick();
        end

        for (int c = 0; c < 3; c++) for (int r = 0; r < 4; r++) keys[c][r] = 1'b0;
        do_reset();
        repeat (PERIOD + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
